// File: rtl/byte_strip_pkg.sv
// Shared definitions for the lane striping / unstriping datapath.
// Holds default geometry, MODE encodings and the active-lane clamp.
package byte_strip_pkg;

  localparam int DEF_W     = 8;
  localparam int DEF_LANES = 4;

  localparam int MODE_X1 = 0;
  localparam int MODE_X2 = 1;
  localparam int MODE_X4 = 2;
  localparam int MODE_X8 = 3;

  // Active lanes = 1<<mode, clamped to the physical lane count.
  function automatic int act_lanes(input int mode, input int lanes);
    int n;
    n = (mode >= 30) ? lanes : (1 << mode);
    return (n > lanes) ? lanes : n;
  endfunction

endpackage

// File: rtl/byte_unstrip_nlane.sv
// N-lane byte unstriper: latches one symbol per active lane per beat
// and replays them serially, lane 0 first, over a valid/ready stream.
module byte_unstrip_nlane
  import byte_strip_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int W     = DEF_W
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [LANES*W-1:0]        LANE_D,
  input  logic [LANES-1:0]          LANE_K,
  input  logic [LANES-1:0]          LANE_VALID,
  output logic                      LANE_READY,
  input  logic [$clog2(LANES):0]    MODE,
  output logic [W-1:0]              D,
  output logic                      DK,
  output logic                      VALID,
  input  logic                      READY,
  output logic                      ERR
);

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW = $clog2(LANES) + 1;

  logic [LANES*W-1:0] buf_d, buf_q;
  logic [LANES-1:0]   k_d, k_q;
  logic               full_d, full_q;
  logic [IW-1:0]      idx_d, idx_q;
  logic [CW-1:0]      act_d, act_q;
  logic               err_d, err_q;

  logic [CW-1:0]      act_new;
  logic [LANES-1:0]   mask;
  logic [LANES-1:0]   act_valid;
  logic               all_valid;
  logic               none_valid;
  logic               at_last;
  logic               pop;
  logic               last_pop;
  logic               accept;

  always_comb begin
    act_new = CW'(act_lanes(int'(MODE), LANES));
    mask = '0;
    for (int i = 0; i < LANES; i++) begin
      mask[i] = (i < int'(act_new));
    end
    act_valid  = LANE_VALID & mask;
    all_valid  = (act_valid == mask);
    none_valid = (act_valid == '0);
  end

  assign at_last    = (int'(idx_q) == int'(act_q) - 1);
  assign pop        = full_q && READY;
  assign last_pop   = pop && at_last;
  assign LANE_READY = !RESET && (!full_q || last_pop);
  assign accept     = LANE_READY && all_valid;

  always_comb begin
    buf_d  = buf_q;
    k_d    = k_q;
    full_d = full_q;
    idx_d  = idx_q;
    act_d  = act_q;
    err_d  = LANE_READY && !all_valid && !none_valid;
    if (pop) begin
      if (!at_last) begin
        idx_d = idx_q + IW'(1);
      end else begin
        full_d = 1'b0;
        idx_d  = '0;
      end
    end
    // A reload on the final pop overrides the drain.
    if (accept) begin
      buf_d  = LANE_D;
      k_d    = LANE_K;
      act_d  = act_new;
      idx_d  = '0;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      buf_q  <= '0;
      k_q    <= '0;
      full_q <= 1'b0;
      idx_q  <= '0;
      act_q  <= CW'(LANES);
      err_q  <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      k_q    <= k_d;
      full_q <= full_d;
      idx_q  <= idx_d;
      act_q  <= act_d;
      err_q  <= err_d;
    end
  end

  assign D     = buf_q[int'(idx_q)*W +: W];
  assign DK    = k_q[idx_q];
  assign VALID = full_q;
  assign ERR   = err_q;

endmodule

// File: tb/tb_byte_unstrip_nlane.sv
// Directed bench for byte_unstrip_nlane (4 lanes, 8-bit symbols).
// Expected values are hand-derived constants.
module tb_byte_unstrip_nlane;

  localparam int LANES = 4;
  localparam int W     = 8;

  logic             CLK = 1'b0;
  logic             RESET;
  logic [31:0]      LANE_D;
  logic [3:0]       LANE_K;
  logic [3:0]       LANE_VALID;
  logic             LANE_READY;
  logic [2:0]       MODE;
  logic [7:0]       D;
  logic             DK;
  logic             VALID;
  logic             READY;
  logic             ERR;

  int n_checks = 0;
  int n_errors = 0;

  byte_unstrip_nlane #(.LANES(LANES), .W(W)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .LANE_D     (LANE_D),
    .LANE_K     (LANE_K),
    .LANE_VALID (LANE_VALID),
    .LANE_READY (LANE_READY),
    .MODE       (MODE),
    .D          (D),
    .DK         (DK),
    .VALID      (VALID),
    .READY      (READY),
    .ERR        (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_sym(input string tag,
                         input logic [7:0] d_exp,
                         input logic v_exp);
    chk({tag, "_v"}, 32'(VALID), 32'(v_exp));
    if (v_exp) chk({tag, "_d"}, 32'(D), 32'(d_exp));
  endtask

  initial begin
    RESET      = 1'b1;
    LANE_D     = '0;
    LANE_K     = '0;
    LANE_VALID = 4'hF;
    MODE       = 3'd2;
    READY      = 1'b1;

    // Reset and idle
    step();
    step();
    chk("rst_valid", 32'(VALID), 32'd0);
    chk("rst_d", 32'(D), 32'd0);
    chk("rst_dk", 32'(DK), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    chk("rst_lready", 32'(LANE_READY), 32'd0);
    RESET      = 1'b0;
    LANE_VALID = 4'h0;
    #1;
    chk("post_rst_lready", 32'(LANE_READY), 32'd1);

    // First beat A3..A0
    LANE_D     = 32'hA3A2A1A0;
    LANE_VALID = 4'hF;
    step();
    LANE_VALID = 4'h0;
    chk_sym("a0", 8'hA0, 1'b1);
    step();
    chk_sym("a1", 8'hA1, 1'b1);
    step();
    chk_sym("a2", 8'hA2, 1'b1);
    step();
    chk_sym("a3", 8'hA3, 1'b1);
    step();
    chk_sym("a_done", 8'h00, 1'b0);

    // Streaming two beats back to back
    LANE_D     = 32'h13121110;
    LANE_VALID = 4'hF;
    step();
    LANE_D = 32'h23222120;
    chk_sym("s10", 8'h10, 1'b1);
    chk("s10_lr", 32'(LANE_READY), 32'd0);
    step();
    chk_sym("s11", 8'h11, 1'b1);
    chk("s11_lr", 32'(LANE_READY), 32'd0);
    step();
    chk_sym("s12", 8'h12, 1'b1);
    step();
    chk_sym("s13", 8'h13, 1'b1);
    chk("s13_lr", 32'(LANE_READY), 32'd1);
    step();
    LANE_VALID = 4'h0;
    chk_sym("s20", 8'h20, 1'b1);
    step();
    chk_sym("s21", 8'h21, 1'b1);
    step();
    chk_sym("s22", 8'h22, 1'b1);
    step();
    chk_sym("s23", 8'h23, 1'b1);
    step();
    chk_sym("s_done", 8'h00, 1'b0);

    // Backpressure on the second symbol
    LANE_D     = 32'h13121110;
    LANE_VALID = 4'hF;
    step();
    LANE_VALID = 4'h0;
    chk_sym("b10", 8'h10, 1'b1);
    step();
    chk_sym("b11", 8'h11, 1'b1);
    READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_lr", 32'(LANE_READY), 32'd0);
      step();
      chk_sym("bp_hold", 8'h11, 1'b1);
    end
    READY = 1'b1;
    step();
    chk_sym("b12", 8'h12, 1'b1);
    step();
    chk_sym("b13", 8'h13, 1'b1);
    step();
    chk_sym("b_done", 8'h00, 1'b0);

    // Mode switch: x2 beat then x1 beat
    MODE       = 3'd1;
    LANE_D     = 32'hFFEEB1B0;
    LANE_VALID = 4'b0011;
    #1;
    chk("m_lr0", 32'(LANE_READY), 32'd1);
    step();
    MODE       = 3'd0;
    LANE_D     = 32'h777766C0;
    LANE_VALID = 4'b1101;
    chk_sym("mb0", 8'hB0, 1'b1);
    chk("mb0_lr", 32'(LANE_READY), 32'd0);
    step();
    chk_sym("mb1", 8'hB1, 1'b1);
    chk("mb1_lr", 32'(LANE_READY), 32'd1);
    chk("mb1_err", 32'(ERR), 32'd0);
    step();
    LANE_VALID = 4'h0;
    chk_sym("mc0", 8'hC0, 1'b1);
    chk("mc0_lr", 32'(LANE_READY), 32'd1);
    step();
    chk_sym("m_done", 8'h00, 1'b0);
    chk("m_err", 32'(ERR), 32'd0);

    // Partial valid, twice in a row, then a clean beat
    MODE       = 3'd2;
    LANE_D     = 32'h33323130;
    LANE_VALID = 4'b0111;
    step();
    chk("p_err1", 32'(ERR), 32'd1);
    chk("p_valid1", 32'(VALID), 32'd0);
    step();
    chk("p_err2", 32'(ERR), 32'd1);
    chk("p_valid2", 32'(VALID), 32'd0);
    LANE_VALID = 4'hF;
    step();
    LANE_VALID = 4'h0;
    chk("p_err3", 32'(ERR), 32'd0);
    chk_sym("p30", 8'h30, 1'b1);
    step();
    chk_sym("p31", 8'h31, 1'b1);
    step();
    chk_sym("p32", 8'h32, 1'b1);
    step();
    chk_sym("p33", 8'h33, 1'b1);
    step();
    chk_sym("p_done", 8'h00, 1'b0);

    // K flag propagation and reset mid-word
    LANE_D     = 32'h444342BC;
    LANE_K     = 4'b0001;
    LANE_VALID = 4'hF;
    step();
    LANE_VALID = 4'h0;
    LANE_K     = 4'b0000;
    chk_sym("kbc", 8'hBC, 1'b1);
    chk("kbc_dk", 32'(DK), 32'd1);
    step();
    chk_sym("k42", 8'h42, 1'b1);
    chk("k42_dk", 32'(DK), 32'd0);
    step();
    chk_sym("k43", 8'h43, 1'b1);
    RESET = 1'b1;
    #1;
    chk("kr_lr", 32'(LANE_READY), 32'd0);
    step();
    RESET = 1'b0;
    chk("kr_valid", 32'(VALID), 32'd0);
    chk("kr_d", 32'(D), 32'd0);
    chk("kr_dk", 32'(DK), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("kr_idle", 32'(VALID), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
